// File: rtl/pwm_demod_if.sv
// Level-in / duty-out bundle of the PWM demodulator.
// master drives the PWM level, slave is the demodulator.
interface pwm_demod_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       pwm_in;
    logic [11:0]      duty;
    logic             duty_valid;
    logic [CNT_W-1:0] period;
    logic             timeout;
    logic             overrun;
    logic             busy;

    modport master (
        output pwm_in,
        input  duty, duty_valid, period, timeout, overrun, busy
    );

    modport slave (
        input  pwm_in,
        output duty, duty_valid, period, timeout, overrun, busy
    );
endinterface

// File: rtl/pwm_demod.sv
// PWM demodulator: measures period and high time of the level stream
// and recovers duty = floor(high*SCALE/period) with a restoring divider.
module pwm_demod #(
    parameter int          SCALE      = 2000,
    parameter int          CNT_W      = 16,
    parameter int          MAX_PERIOD = 20000,
    parameter logic [7:0]  THRESH     = 8'd50
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_demod_if.slave    bus
);
    localparam int NW = CNT_W + 12;

    typedef enum logic {IDLE, MEAS} state_t;

    state_t           state;
    logic             lvl_q, lvl_qq;
    logic             rise;
    logic [CNT_W-1:0] per_cnt, hi_cnt;

    logic [NW-1:0]    rem, dsh;
    logic [11:0]      quo;
    logic [3:0]       it;
    logic [CNT_W-1:0] div_p;
    logic             dbusy;

    logic [11:0]      duty_r;
    logic [CNT_W-1:0] period_r;
    logic             valid_r, timeout_r, overrun_r;

    logic             ge;
    logic [11:0]      q_next;
    logic [NW-1:0]    num;

    assign rise   = lvl_q & ~lvl_qq;
    assign ge     = rem >= dsh;
    assign q_next = {quo[10:0], ge};
    assign num    = NW'(hi_cnt) * NW'(SCALE);

    assign bus.duty       = duty_r;
    assign bus.period     = period_r;
    assign bus.duty_valid = valid_r;
    assign bus.timeout    = timeout_r;
    assign bus.overrun    = overrun_r;
    assign bus.busy       = dbusy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lvl_q     <= 1'b0;
            lvl_qq    <= 1'b0;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            rem       <= '0;
            dsh       <= '0;
            quo       <= '0;
            it        <= '0;
            div_p     <= '0;
            dbusy     <= 1'b0;
            duty_r    <= '0;
            period_r  <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            lvl_q     <= bus.pwm_in >= THRESH;
            lvl_qq    <= lvl_q;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;

            // one quotient bit per cycle, MSB first
            if (dbusy) begin
                if (ge)
                    rem <= rem - dsh;
                quo <= q_next;
                dsh <= dsh >> 1;
                it  <= it - 4'd1;
                if (it == 4'd1) begin
                    dbusy    <= 1'b0;
                    duty_r   <= q_next;
                    period_r <= div_p;
                    valid_r  <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= MEAS;
                        per_cnt   <= CNT_W'(1);
                        hi_cnt    <= CNT_W'(1);
                        timeout_r <= 1'b0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        if (!dbusy) begin
                            rem       <= num;
                            dsh       <= NW'(per_cnt) << 11;
                            quo       <= '0;
                            it        <= 4'd12;
                            div_p     <= per_cnt;
                            dbusy     <= 1'b1;
                            timeout_r <= 1'b0;
                        end else begin
                            overrun_r <= 1'b1;
                        end
                    end else if (per_cnt == CNT_W'(MAX_PERIOD)) begin
                        // overrides a divide finishing this cycle
                        duty_r    <= lvl_q ? 12'(SCALE) : 12'd0;
                        period_r  <= '0;
                        timeout_r <= 1'b1;
                        valid_r   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                        hi_cnt  <= hi_cnt + CNT_W'(lvl_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_demod.sv
// Randomized bench for pwm_demod against a cycle-event model
// built from rise times and high-cycle counts.
module tb_pwm_demod;
    localparam int MAXP = 20000;

    logic clk = 1'b0;
    logic rst_n;

    pwm_demod_if #(.CNT_W(16)) ifc ();

    pwm_demod #(
        .SCALE(2000), .CNT_W(16), .MAX_PERIOD(MAXP), .THRESH(8'd50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n = 0;

    bit lv [100000];

    bit m_meas;
    int last_rise, last_accept;
    int ev_duty [int];
    int ev_per  [int];
    bit ev_ovr  [int];
    bit to_chg  [int];
    bit exp_to;

    int last_duty, last_per;

    int wp, wh, ph, wkind;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     tag, n, got, exp);
        end
    endtask

    function automatic bit lvget(input int i);
        return (i < 0) ? 1'b0 : lv[i];
    endfunction

    task automatic model_clear();
        ev_duty.delete();
        ev_per.delete();
        ev_ovr.delete();
        to_chg.delete();
        m_meas      = 1'b0;
        last_rise   = 0;
        last_accept = -100;
        exp_to      = 1'b0;
    endtask

    // what the DUT sees in cycle t, given drive history
    task automatic step(input int t);
        bit r;
        int p, h;
        r = lvget(t-1) && !lvget(t-2);
        if (r) begin
            if (!m_meas) begin
                m_meas = 1'b1;
                to_chg[t+1] = 1'b0;
            end else begin
                p = t - last_rise;
                h = 0;
                for (int c = last_rise - 1; c <= t - 2; c++)
                    h += lvget(c);
                if (t - last_accept >= 13) begin
                    last_accept = t;
                    ev_duty[t+13] = (h * 2000) / p;
                    ev_per[t+13]  = p;
                    to_chg[t+1]   = 1'b0;
                end else begin
                    ev_ovr[t+1] = 1'b1;
                end
            end
            last_rise = t;
        end else if (m_meas && (t - last_rise == MAXP)) begin
            ev_duty[t+1] = lvget(t-1) ? 2000 : 0;
            ev_per[t+1]  = 0;
            to_chg[t+1]  = 1'b1;
            m_meas       = 1'b0;
        end
    endtask

    task automatic sample_check();
        bit ev;
        if (to_chg.exists(n))
            exp_to = to_chg[n];
        ev = ev_duty.exists(n);
        check("duty_valid", int'(ifc.duty_valid), int'(ev));
        if (ev && ifc.duty_valid) begin
            check("duty", int'(ifc.duty), ev_duty[n]);
            check("period", int'(ifc.period), ev_per[n]);
        end
        if (ifc.duty_valid) begin
            last_duty = int'(ifc.duty);
            last_per  = int'(ifc.period);
        end
        check("overrun", int'(ifc.overrun), int'(ev_ovr.exists(n)));
        check("timeout", int'(ifc.timeout), int'(exp_to));
        check("busy", int'(ifc.busy),
              int'((n - last_accept >= 1) && (n - last_accept <= 12)));
    endtask

    task automatic tick(input logic [7:0] v);
        @(posedge clk);
        #1;
        n++;
        sample_check();
        ifc.pwm_in = v;
        lv[n] = (v >= 8'd50);
        step(n + 1);
    endtask

    task automatic tick_wave();
        logic [7:0] v;
        bit hi;
        hi = (ph < wh);
        unique case (wkind)
            0: v = hi ? 8'd100 : 8'd0;
            1: v = hi ? 8'($urandom_range(50, 255))
                      : 8'($urandom_range(0, 49));
            2: v = hi ? 8'd50 : 8'd49;
            default: v = hi ? 8'd49 : 8'd0;
        endcase
        tick(v);
        ph = (ph + 1) % wp;
    endtask

    task automatic wave(input int p, input int h, input int cyc,
                        input int kind);
        wp = p; wh = h; ph = 0; wkind = kind;
        repeat (cyc) tick_wave();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.pwm_in = 8'd0;
        lv[n] = 1'b0;
        model_clear();
        #1;
        check("rst_duty", int'(ifc.duty), 0);
        check("rst_period", int'(ifc.period), 0);
        check("rst_valid", int'(ifc.duty_valid), 0);
        check("rst_busy", int'(ifc.busy), 0);
        check("rst_timeout", int'(ifc.timeout), 0);
        check("rst_overrun", int'(ifc.overrun), 0);
        repeat (3) tick(8'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int p, h;
        bit found;
        rst_n = 1'b0;
        ifc.pwm_in = 8'd0;
        model_clear();
        last_duty = -1;
        last_per  = -1;
        repeat (3) @(posedge clk);
        #1;
        check("init_duty", int'(ifc.duty), 0);
        check("init_valid", int'(ifc.duty_valid), 0);
        check("init_period", int'(ifc.period), 0);
        check("init_busy", int'(ifc.busy), 0);
        rst_n = 1'b1;

        // constant low: stays idle, no timeout
        repeat (40) tick(8'd0);

        wave(100, 40, 1000, 0);
        check("sq_duty", last_duty, 800);
        check("sq_period", last_per, 100);

        // triangle-like sweep of high time
        for (int k = 0; k < 20; k++) begin
            h = (k < 10) ? 5 + k * 10 : 5 + (19 - k) * 10;
            wave(100, h, 100, 0);
        end

        wave(100, 40, 250, 0);
        repeat (MAXP + 50) tick(8'd100);
        check("to_hi_duty", last_duty, 2000);
        check("to_hi_period", last_per, 0);
        check("to_hi_flag", int'(ifc.timeout), 1);

        wave(100, 40, 250, 0);
        repeat (MAXP + 50) tick(8'd0);
        check("to_lo_duty", last_duty, 0);
        check("to_lo_flag", int'(ifc.timeout), 1);
        wave(100, 40, 300, 0);
        check("to_clear", int'(ifc.timeout), 0);

        wave(10, 5, 200, 0);
        check("ovr_duty", last_duty, 1000);
        check("ovr_period", last_per, 10);

        wave(100, 99, 400, 0);
        check("full_duty", last_duty, 1980);
        wave(65, 1, 400, 0);
        check("min_duty", last_duty, 30);
        check("min_period", last_per, 65);
        wave(64, 20, 300, 2);
        check("thresh_duty", last_duty, 625);
        wave(64, 20, 200, 3);

        // reset in the 5th cycle of a divide
        wave(50, 20, 300, 1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n - last_accept == 5) begin
                found = 1'b1;
                break;
            end
            tick_wave();
        end
        check("rst_mid_found", int'(found), 1);
        do_reset();
        wave(50, 20, 300, 1);

        for (int k = 0; k < 25; k++) begin
            p = $urandom_range(2, 200);
            h = $urandom_range(1, p - 1);
            wave(p, h, p * $urandom_range(2, 3), 1);
        end
        repeat (20) tick(8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
